// File: rtl/muldiv_controller.sv
// rtl/muldiv_controller.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair
module muldiv_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_content,
    input  logic [WIDTH-1:0] rt_content,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;

    // op[0]=1 selects the unsigned variants, op[1]=1 selects divide
    logic             op_signed;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] abs_rs;
    logic [WIDTH-1:0] abs_rt;
    logic             divisor_zero;

    assign op_signed    = ~op[0];
    assign rs_neg       = op_signed & rs_content[WIDTH-1];
    assign rt_neg       = op_signed & rt_content[WIDTH-1];
    assign abs_rs       = rs_neg ? -rs_content : rs_content;
    assign abs_rt       = rt_neg ? -rt_content : rt_content;
    assign divisor_zero = op[1] & (rt_content == '0);

    // Multiply step: conditional add into the upper half, then shift {carry,upper,lower} right.
    logic [WIDTH:0]     msum;
    // Divide step: shift next dividend bit into the remainder and trial-subtract.
    logic [WIDTH:0]     partial;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod_fix;

    assign msum     = {1'b0, upper} + {1'b0, (lower[0] ? operand : {WIDTH{1'b0}})};
    assign partial  = {upper, lower[WIDTH-1]};
    assign diff     = {1'b0, partial} - {2'b00, operand};
    assign prod_fix = neg_lo ? -{upper, lower} : {upper, lower};

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (clk_enable) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = divisor_zero ? FIN : RUN;
            RUN:  if (count == LAST) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            operand     <= '0;
            upper       <= '0;
            lower       <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (clk_enable) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count       <= '0;
                        is_div      <= op[1];
                        div_by_zero <= divisor_zero;
                        if (op[1]) begin
                            // Divide by zero reuses the divide writeback with the raw result preloaded.
                            operand <= abs_rt;
                            upper   <= divisor_zero ? rs_content : '0;
                            lower   <= divisor_zero ? {WIDTH{1'b1}} : abs_rs;
                            neg_lo  <= ~divisor_zero & (rs_neg ^ rt_neg);
                            neg_hi  <= ~divisor_zero & rs_neg;
                        end else begin
                            operand <= abs_rs;
                            upper   <= '0;
                            lower   <= abs_rt;
                            neg_lo  <= rs_neg ^ rt_neg;
                            neg_hi  <= 1'b0;
                        end
                    end else begin
                        if (hi_write) hi <= write_data;
                        if (lo_write) lo <= write_data;
                    end
                end
                RUN: begin
                    count <= count + CW'(1);
                    if (is_div) begin
                        if (!diff[WIDTH+1]) begin
                            upper <= diff[WIDTH-1:0];
                            lower <= {lower[WIDTH-2:0], 1'b1};
                        end else begin
                            upper <= partial[WIDTH-1:0];
                            lower <= {lower[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        upper <= msum[WIDTH:1];
                        lower <= {msum[0], lower[WIDTH-1:1]};
                    end
                end
                FIN: begin
                    if (is_div) begin
                        hi <= neg_hi ? -upper : upper;
                        lo <= neg_lo ? -lower : lower;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_controller.sv
// tb/tb_muldiv_controller.sv - randomized self-checking bench for muldiv_controller
module tb_muldiv_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_controller #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
        .rs_content(rs_content), .rt_content(rt_content), .hi_write(hi_write),
        .lo_write(lo_write), .write_data(write_data), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} using plain 64-bit arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          q;
        longint          r;
        logic [63:0]     p;
        case (o)
            2'd0: begin p = sa * sb; return {1'b0, p}; end
            2'd1: begin p = ua * ub; return {1'b0, p}; end
            2'd2: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                q = longint'(ua / ub);
                r = longint'(ua % ub);
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one operation; mid-run it pokes start and MTHI/MTLO, which must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [64:0] e = model(o, a, b);
        int lat = ((o[1] && b == 0) ? 1 : 33) + stall;
        int n = 0;
        int nb = 0;
        start = 1; op = o; rs_content = a; rt_content = b;
        step();
        start = 0;
        while (!done && n < 200) begin
            if (busy) nb++;
            if (n == 10) begin
                start = 1; op = 2'b01; rs_content = 32'h7; rt_content = 32'h9;
                hi_write = 1; lo_write = 1; write_data = 32'hDEAD_BEEF;
            end else begin
                start = 0; hi_write = 0; lo_write = 0;
            end
            if (n == 4 && stall > 0) clk_enable = 0;
            if (stall > 0 && n == 4 + stall) clk_enable = 1;
            step();
            n++;
        end
        start = 0; hi_write = 0; lo_write = 0; clk_enable = 1;
        check($sformatf("latency op%0d", o), 64'(n), 64'(lat));
        check($sformatf("busy_cycles op%0d", o), 64'(nb), 64'(lat));
        check($sformatf("hi op%0d %h/%h", o, a, b), 64'(hi), 64'(e[63:32]));
        check($sformatf("lo op%0d %h/%h", o, a, b), 64'(lo), 64'(e[31:0]));
        check($sformatf("div_by_zero op%0d", o), 64'(div_by_zero), 64'(e[64]));
        step();
        check("done_single_pulse", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] old_hi;
        int          n;
        int          seen;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;

        reset = 1; clk_enable = 1; start = 0; op = 0; rs_content = 0; rt_content = 0;
        hi_write = 0; lo_write = 0; write_data = 0;
        repeat (2) step();
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dbz", 64'(div_by_zero), 64'd0);
        reset = 0;
        step();

        hi_write = 1; write_data = 32'h1234;
        step();
        hi_write = 0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo_untouched", 64'(lo), 64'd0);
        hi_write = 1; lo_write = 1; write_data = 32'hA5A5_0F0F;
        step();
        hi_write = 0; lo_write = 0;
        check("mthi_mtlo_hi", 64'(hi), 64'hA5A5_0F0F);
        check("mthi_mtlo_lo", 64'(lo), 64'hA5A5_0F0F);

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'd3, 32'd100, 32'd0, 0);
        run_op(2'd1, 32'd2, 32'd3, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'd1, 32'd5, 32'd5, 5);
        run_op(2'd2, 32'hFFFF_FF00, 32'd0, 0);
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 0);

        old_hi = hi;
        start = 1; op = 2'd1; rs_content = 32'd3; rt_content = 32'd3;
        hi_write = 1; write_data = 32'h5555;
        step();
        start = 0; hi_write = 0;
        check("start_wins_over_mthi", 64'(hi), 64'(old_hi));
        n = 0;
        while (!done && n < 100) begin step(); n++; end
        check("start_wins_result_lo", 64'(lo), 64'd9);

        repeat (40) begin
            o = 2'($urandom_range(0, 3));
            a = pick_operand();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
            run_op(o, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        start = 1; op = 2'd0; rs_content = 32'h1234; rt_content = 32'h5678;
        step();
        start = 0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1;
        #2;
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        reset = 0;
        seen = 0;
        repeat (40) begin
            step();
            if (done || busy) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_lo_stays", 64'(lo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
